// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the FP multiply significand path.
package fp_mul_pkg;

    localparam int unsigned MAN_W  = 24;
    localparam int unsigned PROD_W = 2 * MAN_W;
    localparam int unsigned N_DIG  = (MAN_W + 2) / 2;
    localparam int unsigned ACC_W  = PROD_W + 2;
    localparam int unsigned PP_W   = MAN_W + 2;
    localparam int unsigned BX_W   = MAN_W + 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} booth_state_t;
    typedef enum logic [2:0] {BZ, BP1, BP2, BM1, BM2} booth_dig_t;

endpackage

// File: rtl/fp_booth_r4_sel.sv
// Radix-4 Booth triplet decode and signed partial-product select (0, +/-A, +/-2A).
module fp_booth_r4_sel
    import fp_mul_pkg::*;
(
    input  logic [2:0]       trip_i,
    input  logic [MAN_W-1:0] a_i,
    output logic [PP_W-1:0]  pp_o
);

    booth_dig_t      dig;
    logic [PP_W-1:0] a_ext;

    assign a_ext = {2'b00, a_i};

    always_comb begin
        dig = BZ;
        unique case (trip_i)
            3'b000, 3'b111: dig = BZ;
            3'b001, 3'b010: dig = BP1;
            3'b011:         dig = BP2;
            3'b100:         dig = BM2;
            3'b101, 3'b110: dig = BM1;
            default:        dig = BZ;
        endcase
    end

    always_comb begin
        pp_o = '0;
        unique case (dig)
            BZ:      pp_o = '0;
            BP1:     pp_o = a_ext;
            BP2:     pp_o = a_ext << 1;
            BM1:     pp_o = -a_ext;
            BM2:     pp_o = -(a_ext << 1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Multicycle radix-4 Booth significand multiplier: one Booth digit per cycle,
// 13-cycle latency, valid/ready on both sides.
module fp_mul_booth_seq
    import fp_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MAN_W-2:0]  frc_X,
    input  logic [MAN_W-2:0]  frc_Y,
    input  logic              sub_X,
    input  logic              sub_Y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] frc_Z_full,
    output logic              norm_n,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N_DIG - 1);

    booth_state_t      state_q, state_d;
    logic [MAN_W-1:0]  a_q, a_d;
    logic [BX_W-1:0]   b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              norm_q, norm_d;

    logic [PP_W-1:0]   pp;
    logic [ACC_W-1:0]  pp_ext;
    logic [ACC_W-1:0]  pp_sh;

    // b_q holds {zero-ext, B, b[-1]} and shifts right two bits per digit,
    // so the current triplet is always b_q[2:0].
    fp_booth_r4_sel u_sel (
        .trip_i (b_q[2:0]),
        .a_i    (a_q),
        .pp_o   (pp)
    );

    assign pp_ext = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
    assign pp_sh  = pp_ext << {cnt_q, 1'b0};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        norm_d  = norm_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = {~sub_X, frc_X};
                    b_d     = {2'b00, ~sub_Y, frc_Y, 1'b0};
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_q + pp_sh;
                b_d   = b_q >> 2;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DIG) begin
                    prod_d  = acc_d[PROD_W-1:0];
                    norm_d  = acc_d[PROD_W-1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            norm_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            norm_q  <= norm_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == BUSY);
    assign out_valid  = (state_q == DONE);
    assign frc_Z_full = prod_q;
    assign norm_n     = norm_q;

    // Unsigned operands guarantee a non-negative product below 2^48.
    a_acc_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == BUSY && cnt_q == LAST_DIG) |-> (acc_d[ACC_W-1:PROD_W] == '0));

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Scoreboard bench for fp_mul_booth_seq: directed corner cases, back-pressure,
// mid-operation reset and randomised traffic against a plain A*B model.
module tb_fp_mul_booth_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] frc_X = '0;
    logic [22:0] frc_Y = '0;
    logic        sub_X = 1'b0;
    logic        sub_Y = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] frc_Z_full;
    logic        norm_n;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_pushed = 0;
    int unsigned n_popped = 0;
    logic [48:0] exp_q[$];
    bit          rnd_on = 1'b0;

    always #5 clk = ~clk;

    fp_mul_booth_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frc_X      (frc_X),
        .frc_Y      (frc_Y),
        .sub_X      (sub_X),
        .sub_Y      (sub_Y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frc_Z_full (frc_Z_full),
        .norm_n     (norm_n),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] model(input logic [22:0] fx, input logic sx,
                                          input logic [22:0] fy, input logic sy);
        logic [47:0] a, b, p;
        a = {24'd0, ~sx, fx};
        b = {24'd0, ~sy, fy};
        p = a * b;
        return {p[47], p};
    endfunction

    // Output side: every handshake pops one expected result.
    always @(negedge clk) begin
        logic [48:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("prod", 64'(frc_Z_full), 64'(e[47:0]));
                check("norm", 64'(norm_n), 64'(e[48]));
                n_popped++;
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_on) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input logic [22:0] fx, input logic sx, input logic [22:0] fy,
                         input logic sy, input bit push);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(0), 64'(1));
            return;
        end
        frc_X = fx; sub_X = sx; frc_Y = fy; sub_Y = sy;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (push) begin
            exp_q.push_back(model(fx, sx, fy, sy));
            n_pushed++;
        end
    endtask

    task automatic latency_op(input string tag, input logic [22:0] fx, input logic sx,
                              input logic [22:0] fy, input logic sy,
                              input logic [47:0] exp_p, input logic exp_n);
        int unsigned n;
        out_ready = 1'b1;
        issue(fx, sx, fy, sy, 1'b1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1 n++;
            if (n == 1) begin
                check({tag, "_busy"}, 64'(busy), 64'(1));
                check({tag, "_inrdy_busy"}, 64'(in_ready), 64'(0));
            end
            if (out_valid) break;
        end
        check({tag, "_latency"}, 64'(n), 64'(13));
        check({tag, "_value"}, 64'(frc_Z_full), 64'(exp_p));
        check({tag, "_normn"}, 64'(norm_n), 64'(exp_n));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [48:0] bp;
        int unsigned n;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_prod", 64'(frc_Z_full), 64'(0));
        check("rst_normn", 64'(norm_n), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        latency_op("three_sq", 23'h400000, 1'b0, 23'h400000, 1'b0, 48'h900000000000, 1'b1);
        latency_op("one_sq", 23'h000000, 1'b0, 23'h000000, 1'b0, 48'h400000000000, 1'b0);
        latency_op("max", 23'h7FFFFF, 1'b0, 23'h7FFFFF, 1'b0, 48'hFFFFFE000001, 1'b1);
        bp = model(23'h2DF854, 1'b1, 23'h490FDB, 1'b0);
        latency_op("subx", 23'h2DF854, 1'b1, 23'h490FDB, 1'b0, bp[47:0], bp[48]);
        latency_op("zero_x", 23'h000000, 1'b1, 23'h5A5A5A, 1'b0, 48'h0, 1'b0);
        latency_op("zero_both", 23'h000000, 1'b1, 23'h000000, 1'b1, 48'h0, 1'b0);

        // Back-pressure in DONE with stray in_valid pulses.
        out_ready = 1'b0;
        issue(23'h123456, 1'b0, 23'h654321, 1'b0, 1'b1);
        bp = model(23'h123456, 1'b0, 23'h654321, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        for (int i = 0; i < 5; i++) begin
            frc_X = 23'h7FFFFF; frc_Y = 23'h0F0F0F;
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("bp_prod", 64'(frc_Z_full), 64'(bp[47:0]));
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_inrdy", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_inrdy", 64'(in_ready), 64'(1));
        check("bp_release_valid", 64'(out_valid), 64'(0));
        latency_op("after_bp", 23'h400000, 1'b0, 23'h000000, 1'b0, 48'h600000000000, 1'b0);

        // Reset in the middle of BUSY abandons the operation.
        issue(23'h3C3C3C, 1'b0, 23'h2A2A2A, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_prod", 64'(frc_Z_full), 64'(0));
        check("mid_rst_inrdy", 64'(in_ready), 64'(1));
        check("mid_rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        latency_op("after_rst", 23'h7FFFFF, 1'b0, 23'h400000, 1'b0, 48'hBFFFFF400000, 1'b1);

        // Random traffic with random back-pressure.
        rnd_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            issue(23'($urandom), ($urandom_range(0, 7) == 0),
                  23'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        rnd_on = 1'b0;
        #2 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        check("txn_count", 64'(n_popped), 64'(n_pushed));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
